// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation codes, FSM state codes, result bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_unit_pkg;

    // Operation codes carried on the decoder's MDUOp field.
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_t;

    // Two-state sequencer: waiting for work, or counting down a latency.
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    // HI/LO pair produced by the arithmetic datapath.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    // True for the four ops that occupy the unit for a fixed latency.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the two divide ops, which use the longer latency.
    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: 64-bit products, quotient/remainder for the latched op.
// Latency: 0 cycles, purely combinational from the latched operands.
// Backpressure: none; wr drops for a zero divisor so HI/LO are left untouched.
module mdu_calc import mdu_unit_pkg::*; (
    input  mdu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output mdu_res_t    res,
    output logic        wr
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Products, and divides done on magnitudes with signs re-applied afterwards.
    always_comb begin
        // Low 64 bits of the sign-extended product equal the signed 32x32 product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Keep the divider well-defined on a zero divisor; the result is discarded.
        div_b  = (b == 32'd0) ? 32'd1 : b;

        q_u    = a / div_b;
        r_u    = a % div_b;

        a_mag  = a[31] ? (~a + 32'd1) : a;
        b_mag  = b[31] ? (~b + 32'd1) : div_b;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;

        // Quotient truncates toward zero; remainder follows the dividend's sign.
        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negated wraps
        // back to 0x80000000 with remainder 0.
        q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;
    end

    // Select the result for the latched op and flag whether it should commit.
    always_comb begin
        res = '0;
        wr  = 1'b0;
        case (op)
            MDU_MULT: begin
                res = prod_s;
                wr  = 1'b1;
            end
            MDU_MULTU: begin
                res = prod_u;
                wr  = 1'b1;
            end
            MDU_DIV: begin
                res.hi = r_s;
                res.lo = q_s;
                wr     = (b != 32'd0);
            end
            MDU_DIVU: begin
                res.hi = r_u;
                res.lo = q_u;
                wr     = (b != 32'd0);
            end
            default: begin
                res = '0;
                wr  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; mfhi/mflo read hi/lo directly.
// Latency: MULT_CYCLES / DIV_CYCLES edges after the start edge; MTHI/MTLO write on the next edge.
// Backpressure: busy (start | busy_q) stalls MDU instructions; requests while running are dropped.
module mdu_unit import mdu_unit_pkg::*; #(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_t     state_q;
    mdu_state_t     state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    mdu_op_t        op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;

    logic           accept;
    logic           load;
    logic           commit;
    logic           mthi;
    logic           mtlo;
    mdu_res_t       calc_res;
    logic           calc_wr;

    // A request is only honoured when idle and not flushed by an exception.
    assign accept = (state_q == MDU_IDLE) && !req;
    assign mthi   = accept && (op == MDU_MTHI);
    assign mtlo   = accept && (op == MDU_MTLO);

    // Next-state and counter logic for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (accept && start && is_muldiv(op)) begin
                    state_d = MDU_RUN;
                    cnt_d   = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    load    = 1'b1;
                end
            end
            MDU_RUN: begin
                // Final edge of the latency: results land as busy_q falls.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = MDU_IDLE;
                    commit  = 1'b1;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture operands and op at launch so RUN is insensitive to bypass changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= MDU_NOP;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load) begin
            op_q <= mdu_op_t'(op);
            a_q  <= rs_data;
            b_q  <= rt_data;
        end
    end

    mdu_calc u_calc (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (calc_res),
        .wr  (calc_wr)
    );

    // HI/LO update: arithmetic commit at end of RUN, or direct move while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (calc_wr) begin
                hi_q <= calc_res.hi;
                lo_q <= calc_res.lo;
            end
        end else begin
            if (mthi) begin
                hi_q <= rs_data;
            end
            if (mtlo) begin
                lo_q <= rs_data;
            end
        end
    end

    assign busy = start | (state_q == MDU_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized traffic vs. a behavioural model.
// Latency: model tracks the remaining busy cycles of the operation in flight.
// Backpressure: random traffic keeps issuing requests while busy; they must have no effect.
module tb_mdu_unit;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_wr = 1'b0;

    mdu_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of an MDU op, straight from the arithmetic rules.
    task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output bit w);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        rh = '0; rl = '0; w = 1'b0;
        case (o)
            OP_MULT: begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                {rh, rl} = sp;
                w = 1'b1;
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                {rh, rl} = up;
                w = 1'b1;
            end
            OP_DIV: begin
                if (b != 0) begin
                    w = 1'b1;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        rl = 32'h8000_0000; rh = 32'h0;
                    end else begin
                        sa = a; sb = b;
                        rl = sa / sb;
                        rh = sa % sb;
                    end
                end
            end
            OP_DIVU: begin
                if (b != 0) begin
                    w = 1'b1;
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: w = 1'b0;
        endcase
    endtask

    // Model: advance on each rising edge from the inputs presented in that cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; p_wr = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (!req) begin
            if (start && op >= OP_MULT && op <= OP_DIVU) begin
                m_left = (op >= OP_DIV) ? N_DIV : N_MULT;
                compute(op, rs_data, rt_data, p_hi, p_lo, p_wr);
            end else if (op == OP_MTHI) begin
                m_hi = rs_data;
            end else if (op == OP_MTLO) begin
                m_lo = rs_data;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(start | (m_left > 0)));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        @(posedge clk);
        #2;
        start = s; op = o; rs_data = a; rt_data = b; req = r;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, $urandom, $urandom, 1'b0);
    endtask

    // Count cycles busy stays high after the start cycle, bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            #1;
            if (busy) n++;
            else break;
        end
    endtask

    function automatic logic [31:0] pickv();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        // MULT -2 * 3
        drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        #1 chk("mult_busy_start", 32'(busy), 32'h1);
        count_busy(n);
        chk("mult_busy_len", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max * max
        drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        count_busy(n);
        chk("multu_busy_len", n, 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        count_busy(n);
        chk("div_busy_len", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero leaves HI/LO alone
        drive(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
        count_busy(n);
        chk("divz_busy_len", n, 32'd10);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        chk("divz_lo", lo, 32'hFFFF_FFFD);

        // DIV overflow case
        drive(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        count_busy(n);
        chk("divov_lo", lo, 32'h8000_0000);
        chk("divov_hi", hi, 32'h0);

        // MTHI in idle
        drive(1'b0, OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        #1 chk("mthi_busy", 32'(busy), 32'h0);
        idle();
        #1 chk("mthi_hi", hi, 32'h1234_5678);

        // MTLO and a forced start during RUN of MULT are dropped
        drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        drive(1'b0, OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b0);
        drive(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0);
        count_busy(n);
        chk("mtlo_run_len", n, 32'd3);
        chk("mtlo_run_lo", lo, 32'd42);
        chk("mtlo_run_hi", hi, 32'd0);

        // start together with req is flushed
        drive(1'b1, OP_MULT, 32'd5, 32'd5, 1'b1);
        idle();
        #1 chk("req_start_busy", 32'(busy), 32'h0);
        chk("req_start_lo", lo, 32'd42);

        // req during RUN does not abort
        drive(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
        drive(1'b0, OP_MTHI, 32'hAAAA_AAAA, 32'h0, 1'b1);
        count_busy(n);
        chk("req_run_len", n, 32'd4);
        chk("req_run_lo", lo, 32'd12);
        chk("req_run_hi", hi, 32'd0);

        // Reset at cycle 4 of a DIV: immediate clear, no late commit
        drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (14) idle();
        #1;
        chk("rstmid_late_hi", hi, 32'h0);
        chk("rstmid_late_lo", lo, 32'h0);

        // Randomized traffic, including requests while busy and flushes
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 3) != 0, 3'($urandom_range(0, 7)), pickv(), pickv(),
                  ($urandom % 10) == 0);
        end
        repeat (12) idle();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit; responder to the decoder's MDU_start / MDUOp request.
- Latches operands on a start request and counts a fixed latency.
- Commits results to the HI/LO registers and exposes a busy flag that the hazard logic uses to stall MDU-related instructions.
- mfhi/mflo read hi/lo directly through AO_sel.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  1  exception/interrupt flush; E-stage instruction is cancelled this cycle
- start  input  1  MDU_start from decoder, E stage
- op  input  3  MDUOp code
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- busy  output  1  start | busy_q, combinational
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n), clock is clk.
- Reset values: hi=0, lo=0, busy_q=0, cnt=0, latched operands=0, latched op=NOP. busy follows combinationally (=start).
- States:
  - IDLE (busy_q=0)
  - RUN (busy_q=1, cnt counts down)
- IDLE -> RUN: rising edge with start=1, req=0, op in {MULT,MULTU,DIV,DIVU}.
  - Latch rs_data, rt_data and op.
  - cnt <= MULT_CYCLES or DIV_CYCLES.
- RUN: each edge decrements cnt. On the edge where cnt==1, do the following, so busy_q is high for exactly N cycles after the start edge and new hi/lo are visible in the cycle after busy_q falls:
  - write hi/lo;
  - busy_q <= 0;
  - go to IDLE.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo/hi = unsigned quotient/remainder.
  - Divisor 0 (DIV/DIVU): cycle count is still spent; hi/lo left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Accepted in IDLE with req=0; start is 0 for these ops.
  - hi (or lo) <= rs_data on the same edge; no busy.
  - Qualifier is op alone.
- op=NOP with start=0: no effect.
- req=1: any start/MTHI/MTLO in the same cycle is ignored (instruction flushed).
  - An operation already in RUN is NOT aborted; it completes and commits normally.
- Requests (start, MTHI, MTLO) arriving while busy_q=1 are ignored.
  - The hazard unit guarantees they do not occur; the verifier checks they have no effect if forced.
- start=1 with a non-mult/div op: ignored.
- rst_n low mid-RUN: immediately returns to IDLE with the reset values above; the pending result is lost.
- Operands used for the result are the latched copies; changes on rs_data/rt_data during RUN have no effect.

Decomposition:
- Shared header constants.v, beside the existing decoder constants:
  - MDU_NOP=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - MDU_IDLE / MDU_RUN state codes.
- The result datapath (64-bit product, quotient/remainder incl. the zero and overflow cases) goes in one combinational sub-module mdu_calc, fed from the latched operands.
- mdu_unit holds the FSM, counter and HI/LO registers.

Test Plan:
- Reset -> hi=0, lo=0, busy=0.
  - start, MULT, rs=0xFFFFFFFE (-2), rt=3.
  - Response: busy=1 in the start cycle plus 5 more cycles, then 0.
  - After completion: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2:
  - busy for 10 cycles after the start edge;
  - then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU rs=7, rt=0: hi/lo unchanged after 10 cycles.
- MTHI rs=0x12345678 in IDLE -> hi=0x12345678 next edge, busy never asserted.
  - MTLO during RUN of a MULT -> lo equals the product only; MTLO value discarded.
- start MULT together with req=1 -> busy_q stays 0, hi/lo unchanged.
  - Separately, assert req during RUN -> operation still commits on schedule.
- rst_n pulsed low at cycle 4 of a DIV -> busy=0, hi=lo=0 immediately; no late commit afterwards.
